ct_merge: RTL and testbench
===========================

# ct_merge

Packet-aware N-to-1 merge node for the interconnect fabric. It arbitrates among NI valid/ready input streams, which typically come from the outputs of upstream split nodes, and forwards one stream at a time onto a single output. Grants rotate round-robin. A grant stays locked from the first beat of a packet through its end-of-packet beat, so packets from different sources are never interleaved.

## Interface
- NI, 2: number of inputs (≥2)
- WO, 1: width of data per input/output
- WF, 1: width of flow_id

- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- i_data  in  NI*WO  input data; input k occupies [WO*k +: WO]
- i_valid  in  NI  per-input valid
- i_eop  in  NI  per-input end-of-packet marker
- i_flow  in  NI*WF  per-input flow_id; input k occupies [WF*k +: WF]
- o_ready  out  NI  per-input ready; at most one bit high
- o_data  out  WO  merged data
- o_valid  out  1  merged valid
- o_eop  out  1  merged end-of-packet
- o_flow  out  WF  merged flow_id
- i_ready  in  1  downstream ready

## Operation
- **Transfer rule.** A transfer occurs on an interface when valid and ready are both high at a rising edge. Upstream must hold valid, data, eop and flow stable until the beat transfers. The block guarantees the same on its output.
- **Round-robin pointer.** `rr_last` (log2 NI bits) records the last granted input.
- **Grant search.** The search starts at input `(rr_last+1) mod NI` and wraps through NI-1 to 0. The first input with i_valid=1 wins.
- **State machine.** Registered grant index `g`.
  - **IDLE:** grant is combinational from the search above. If no input is valid: o_valid=0 and o_ready=0.
    - Winner transfers with eop=1: stay IDLE, rr_last←winner.
    - Winner transfers with eop=0: go to PKT, g←winner, rr_last←winner.
    - Winner offered but i_ready=0: go to HOLD, g←winner.
  - **HOLD:** grant fixed at g; o_valid = i_valid[g]. Other inputs are ignored even if they become valid.
    - Transfer with eop=1: go to IDLE, rr_last←g.
    - Transfer with eop=0: go to PKT, rr_last←g.
  - **PKT:** grant fixed at g. Gaps in i_valid[g] are allowed; o_valid follows i_valid[g].
    - Transfer with eop=1: go to IDLE.
- **Routing.** o_data, o_eop and o_flow = the selected input's fields. o_ready[k] = i_ready & (k == grant), with the grant valid.
- **Single-beat packets.** Single-beat packets (eop=1 on every beat) rotate fairly with no bubble between grants.
- **Unsupported behaviour.** If valid drops in HOLD (a protocol violation), the block stays in HOLD. A simulation-only assertion flags it.

## Timing
- **Reset values.** While reset is high: state=IDLE, rr_last=NI-1 (input 0 gets first priority), o_valid=0, o_ready='0, o_eop=0. o_data and o_flow are don't-care.
- **Latency (macro off).** Zero cycles; input-to-output is purely combinational. Full throughput: one beat per cycle.
- **Back-to-back packets.** A new packet can be granted in the cycle immediately following an eop transfer.
- **Simultaneous events.** All NI inputs valid in the same cycle: exactly one is granted, per the pointer.
- **eop when already locked.** eop on the first beat while in HOLD: return directly to IDLE.
- **Reset mid-packet.** The lock is dropped and the next grant goes to input 0. Packets upstream are the upstream's responsibility.

## Configuration
- **Macro:** `CT_MERGE_OREG_EN`.
- **Defined:** a 2-entry output skid buffer is inserted after the mux.
  - o_data, o_valid, o_eop and o_flow are registered; latency is 1 cycle.
  - Internal ready = buffer not full, so input-side o_ready no longer depends combinationally on i_ready.
  - Throughput stays at one beat per cycle.
  - Buffer resets empty; o_valid=0.
  - The arbiter state machine sees the buffer's ready as its i_ready.
- **Undefined:** purely combinational datapath as described above.

## Test plan
- **Reset priority:** hold reset, then release with all NI=4 inputs valid carrying single-beat packets, i_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; o_valid=0 during reset.
- **Packet locking:** input 1 sends a 3-beat packet (flow 5, eop on beat 3) while input 2 is continuously valid -> three beats of flow 5 are output contiguously, then input 2 is granted the next cycle.
- **Grant held under back-pressure:** input 0 valid with i_ready=0 for 4 cycles, input 3 becomes valid in cycle 2 -> o_ready[0] stays granted, o_data is stable for all 4 cycles, input 3 is granted only after input 0's eop transfer.
- **Valid gaps mid-packet:** input 2 deasserts valid for 2 cycles mid-packet while input 0 is valid -> o_valid=0 during the gap, no grant to input 0 until input 2's eop.
- **Reset mid-packet:** assert reset in beat 2 of a 4-beat packet from input 3 -> outputs reach reset values immediately; after release, input 0 wins if valid.
- **Skid buffer (with CT_MERGE_OREG_EN):** random i_ready toggling, 1000 beats -> every beat is delivered exactly once, in order, with 1-cycle latency at i_ready=1.

Source files
------------

// File: rtl/ct_merge.sv
// ct_merge: packet-aware round-robin N-to-1 merge with grant locking for whole packets.
// Optional CT_MERGE_OREG_EN inserts a 2-entry output skid buffer (1-cycle latency).
module ct_merge #(
  parameter int NI = 2,
  parameter int WO = 1,
  parameter int WF = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NI*WO-1:0] i_data,
  input  logic [NI-1:0]    i_valid,
  input  logic [NI-1:0]    i_eop,
  input  logic [NI*WF-1:0] i_flow,
  output logic [NI-1:0]    o_ready,
  output logic [WO-1:0]    o_data,
  output logic             o_valid,
  output logic             o_eop,
  output logic [WF-1:0]    o_flow,
  input  logic             i_ready
);

  localparam int RW = (NI > 1) ? $clog2(NI) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_PKT} state_t;

  state_t          r_state;
  logic [RW-1:0]   r_rr_last;
  logic [RW-1:0]   r_g;

  logic [RW-1:0]   w_idx;
  logic [RW-1:0]   w_win;
  logic            w_any;
  logic [RW-1:0]   w_gnt;
  logic            w_gvld;
  logic            w_mvalid;
  logic [WO-1:0]   w_mdata;
  logic [WF-1:0]   w_mflow;
  logic            w_meop;
  logic            w_rdy_int;
  logic            w_xfer;

  // Descending scan so the input closest after rr_last is the last (winning) write.
  always_comb begin
    w_idx = '0;
    w_win = '0;
    w_any = 1'b0;
    for (int off = NI; off >= 1; off--) begin
      w_idx = RW'((int'(r_rr_last) + off) % NI);
      if (i_valid[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
  end

  assign w_gnt    = (r_state == S_IDLE) ? w_win : r_g;
  assign w_gvld   = ~reset & ((r_state == S_IDLE) ? w_any : 1'b1);
  assign w_mvalid = w_gvld & i_valid[w_gnt];
  assign w_xfer   = w_mvalid & w_rdy_int;

  always_comb begin
    w_mdata = '0;
    w_mflow = '0;
    w_meop  = 1'b0;
    o_ready = '0;
    for (int k = 0; k < NI; k++) begin
      if (w_gnt == RW'(k)) begin
        w_mdata    = i_data[WO*k +: WO];
        w_mflow    = i_flow[WF*k +: WF];
        w_meop     = i_eop[k];
        o_ready[k] = w_rdy_int & w_gvld;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr_last <= RW'(NI - 1);
      r_g       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_g <= w_win;
            if (w_rdy_int) begin
              r_rr_last <= w_win;
              if (!w_meop) r_state <= S_PKT;
            end else begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_xfer) begin
            r_rr_last <= r_g;
            r_state   <= w_meop ? S_IDLE : S_PKT;
          end
        end
        S_PKT: begin
          if (w_xfer && w_meop) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CT_MERGE_OREG_EN
  localparam int BW = WO + WF + 1;

  logic [1:0]    r_cnt;
  logic [BW-1:0] r_b0;
  logic [BW-1:0] r_b1;
  logic [BW-1:0] w_mbeat;
  logic          w_pop;

  assign w_mbeat   = {w_mdata, w_mflow, w_meop};
  assign w_rdy_int = (r_cnt != 2'd2);
  assign w_pop     = (r_cnt != 2'd0) & i_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_xfer, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Head entry refills from the mux when it would otherwise drain empty.
  always_ff @(posedge clk) begin
    if (w_xfer && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop))) r_b0 <= w_mbeat;
    else if (w_pop)                                             r_b0 <= r_b1;
    if (w_xfer) r_b1 <= w_mbeat;
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_b0[BW-1 -: WO];
  assign o_flow  = r_b0[WF:1];
  assign o_eop   = o_valid & r_b0[0];
`else
  assign w_rdy_int = i_ready;
  assign o_valid   = w_mvalid;
  assign o_data    = w_mdata;
  assign o_flow    = w_mflow;
  assign o_eop     = w_mvalid & w_meop;
`endif

`ifndef SYNTHESIS
  a_hold_valid: assert property (@(posedge clk) disable iff (reset)
    (r_state == S_HOLD) |-> i_valid[r_g]);
`endif

endmodule

// File: tb/tb_ct_merge.sv
// Directed scoreboard bench for ct_merge (NI=4, combinational datapath build).
module tb_ct_merge;
  localparam int NI = 4;
  localparam int WO = 8;
  localparam int WF = 4;

  typedef logic [WO+WF:0] beat_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [NI*WO-1:0] i_data;
  logic [NI-1:0]    i_valid;
  logic [NI-1:0]    i_eop;
  logic [NI*WF-1:0] i_flow;
  logic [NI-1:0]    o_ready;
  logic [WO-1:0]    o_data;
  logic             o_valid;
  logic             o_eop;
  logic [WF-1:0]    o_flow;
  logic             i_ready;

  logic [WO-1:0] d [NI];
  logic [WF-1:0] f [NI];
  logic [NI-1:0] v;
  logic [NI-1:0] e;

  beat_t q[$];
  beat_t mon_exp;
  int    n_tests = 0;
  int    n_fail  = 0;

  ct_merge #(.NI(NI), .WO(WO), .WF(WF)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .i_eop(i_eop),
    .i_flow(i_flow), .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid),
    .o_eop(o_eop), .o_flow(o_flow), .i_ready(i_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    i_data  = '0;
    i_flow  = '0;
    i_valid = v;
    i_eop   = e;
    for (int k = 0; k < NI; k++) begin
      i_data[WO*k +: WO] = d[k];
      i_flow[WF*k +: WF] = f[k];
    end
  end

  function automatic beat_t mk(int data, int flow, bit eop);
    return {WO'(data), WF'(flow), eop};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(int k, bit vv, int dd, int ff, bit ee);
    v[k] = vv;
    d[k] = WO'(dd);
    f[k] = WF'(ff);
    e[k] = ee;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted output beat must match the queue head.
  always @(negedge clk) begin
    if (!reset && o_valid && i_ready) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got %h expected none", {o_data, o_flow, o_eop});
      end else begin
        mon_exp = q.pop_front();
        if ({o_data, o_flow, o_eop} !== mon_exp) begin
          n_fail++;
          $display("FAIL out_beat: got %h expected %h", {o_data, o_flow, o_eop}, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    i_ready = 1'b1;
    v = '0;
    e = '0;
    for (int k = 0; k < NI; k++) begin
      d[k] = '0;
      f[k] = '0;
    end

    // Reset priority: all four single-beat sources, grants 0,1,2,3,0
    for (int k = 0; k < NI; k++) set_in(k, 1, 'hA0 + k, k, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_eop",   32'(o_eop), 0);
    for (int i = 0; i < 5; i++) q.push_back(mk('hA0 + (i % 4), i % 4, 1));
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_grant", 32'(o_ready), 32'(1 << (i % 4)));
      step();
    end
    v = '0;

    // Packet locking: input 1 three beats flow 5, input 2 waiting
    set_in(1, 1, 'h11, 5, 0);
    set_in(2, 1, 'h21, 2, 1);
    q.push_back(mk('h11, 5, 0));
    q.push_back(mk('h12, 5, 0));
    q.push_back(mk('h13, 5, 1));
    q.push_back(mk('h21, 2, 1));
    @(negedge clk); chk("lock_b1", 32'(o_ready), 32'h2); step();
    set_in(1, 1, 'h12, 5, 0);
    @(negedge clk); chk("lock_b2", 32'(o_ready), 32'h2); step();
    set_in(1, 1, 'h13, 5, 1);
    @(negedge clk); chk("lock_b3", 32'(o_ready), 32'h2); step();
    v[1] = 1'b0;
    @(negedge clk); chk("lock_next", 32'(o_ready), 32'h4); step();
    v[2] = 1'b0;

    // Back-pressure: input 0 held for 4 cycles, input 3 arrives in cycle 2
    i_ready = 1'b0;
    set_in(0, 1, 'h01, 1, 0);
    q.push_back(mk('h01, 1, 0));
    q.push_back(mk('h02, 1, 1));
    q.push_back(mk('h31, 3, 1));
    for (int c = 0; c < 4; c++) begin
      if (c == 1) set_in(3, 1, 'h31, 3, 1);
      @(negedge clk);
      chk("bp_valid", 32'(o_valid), 1);
      chk("bp_data",  32'(o_data), 32'h01);
      chk("bp_ready", 32'(o_ready), 0);
      step();
    end
    i_ready = 1'b1;
    @(negedge clk); chk("bp_release", 32'(o_ready), 32'h1); step();
    set_in(0, 1, 'h02, 1, 1);
    @(negedge clk); chk("bp_beat2", 32'(o_ready), 32'h1); step();
    v[0] = 1'b0;
    @(negedge clk); chk("bp_next", 32'(o_ready), 32'h8); step();
    v[3] = 1'b0;

    // Valid gap mid-packet on input 2 while input 0 waits
    set_in(2, 1, 'h25, 6, 0);
    q.push_back(mk('h25, 6, 0));
    q.push_back(mk('h26, 6, 1));
    q.push_back(mk('h05, 0, 1));
    @(negedge clk); chk("gap_b1", 32'(o_ready), 32'h4); step();
    v[2] = 1'b0;
    set_in(0, 1, 'h05, 0, 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("gap_valid", 32'(o_valid), 0);
      chk("gap_ready", 32'(o_ready), 32'h4);
      step();
    end
    set_in(2, 1, 'h26, 6, 1);
    @(negedge clk); chk("gap_b2", 32'(o_ready), 32'h4); step();
    v[2] = 1'b0;
    @(negedge clk); chk("gap_next", 32'(o_ready), 32'h1); step();
    v[0] = 1'b0;

    // Reset in beat 2 of a packet from input 3
    set_in(3, 1, 'h35, 7, 0);
    q.push_back(mk('h35, 7, 0));
    q.push_back(mk('h07, 1, 1));
    @(negedge clk); chk("mid_b1", 32'(o_ready), 32'h8); step();
    set_in(3, 1, 'h36, 7, 0);
    set_in(0, 1, 'h07, 1, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid_now", 32'(o_valid), 0);
    @(negedge clk);
    chk("mid_rst_valid", 32'(o_valid), 0);
    chk("mid_rst_ready", 32'(o_ready), 0);
    step();
    reset = 1'b0;
    @(negedge clk); chk("mid_after", 32'(o_ready), 32'h1); step();
    v = '0;

    repeat (3) step();
    chk("queue_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
